// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver, the RX pin and the user logic.
// The receiver takes the slave side; user logic or a bench takes the master side.
interface uart_rx_if;
    logic       i_en;
    logic [2:0] i_baud_rate;
    logic       i_data_size;
    logic       i_parity_en;
    logic [1:0] i_parity_mode;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_ready;
    logic       o_new_data;
    logic       o_uart_clock;

    modport slave (
        input  i_en, i_baud_rate, i_data_size, i_parity_en, i_parity_mode, i_rx,
        output o_data, o_valid, o_ready, o_new_data, o_uart_clock
    );

    modport master (
        output i_en, i_baud_rate, i_data_size, i_parity_en, i_parity_mode, i_rx,
        input  o_data, o_valid, o_ready, o_new_data, o_uart_clock
    );
endinterface

// File: rtl/uart_rx.sv
// Asynchronous serial receiver: centre-samples 7/8-bit frames with optional parity
// and reports each completed frame with a one-cycle new_data strobe.
//   state  | meaning
//   IDLE   | waiting for a low synchronized rx while enabled
//   START  | half a bit period in, confirm the start bit
//   DATA   | sampling data bits LSB first, one per bit period
//   PARITY | sampling and checking the parity bit
//   STOP   | sampling the stop bit, then publishing the frame
module uart_rx #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int unsigned T0 = (CLK_HZ + 230_400) / 460_800;
    localparam int unsigned T1 = (CLK_HZ + 115_200) / 230_400;
    localparam int unsigned T2 = (CLK_HZ + 57_600) / 115_200;
    localparam int unsigned T3 = (CLK_HZ + 28_800) / 57_600;
    localparam int unsigned T4 = (CLK_HZ + 19_200) / 38_400;
    localparam int unsigned T5 = (CLK_HZ + 9_600) / 19_200;
    localparam int unsigned T6 = (CLK_HZ + 4_800) / 9_600;
    localparam int unsigned T7 = (CLK_HZ + 2_400) / 4_800;
    localparam int CNT_W = $clog2(T7 + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_baud;
    logic             r_size;
    logic             r_par_en;
    logic [1:0]       r_par_mode;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_idx;
    logic             r_par_ok;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_new_data;
    logic             r_uclk;

    logic             w_start;
    logic             w_done;
    logic             w_tick;
    logic             w_last_bit;
    logic             w_par_exp;
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_fall;
    logic [CNT_W-1:0] w_half_in;

    function automatic logic [CNT_W-1:0] period_of(input logic [2:0] sel);
        case (sel)
            3'd0:    return CNT_W'(T0);
            3'd1:    return CNT_W'(T1);
            3'd2:    return CNT_W'(T2);
            3'd3:    return CNT_W'(T3);
            3'd4:    return CNT_W'(T4);
            3'd5:    return CNT_W'(T5);
            3'd6:    return CNT_W'(T6);
            default: return CNT_W'(T7);
        endcase
    endfunction

    // Start detection uses the live select; the rest of the frame uses the latched one.
    assign w_period   = period_of(r_baud);
    assign w_fall     = w_period - (w_period >> 1);
    assign w_half_in  = (period_of(bus.i_baud_rate) >> 1) - CNT_W'(1);
    assign w_tick     = (r_cnt == '0);
    assign w_last_bit = (r_bit_idx == (r_size ? 3'd7 : 3'd6));

    always_comb begin
        w_par_exp = 1'b0;
        case (r_par_mode)
            2'b11:   w_par_exp = ~(^r_shift);
            2'b10:   w_par_exp = ^r_shift;
            2'b01:   w_par_exp = 1'b1;
            default: w_par_exp = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= bus.i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_sync) begin
                    w_next  = S_START;
                    w_start = 1'b1;
                end
            end
            S_START:  if (w_tick) w_next = r_rx_sync ? S_IDLE : S_DATA;
            S_DATA:   if (w_tick && w_last_bit) w_next = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_tick) w_next = S_STOP;
            S_STOP: begin
                if (w_tick) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
            default:  w_next = S_IDLE;
        endcase
        if (!bus.i_en) begin
            w_next  = S_IDLE;
            w_start = 1'b0;
            w_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_baud     <= '0;
            r_size     <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_mode <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_par_ok   <= 1'b1;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_new_data <= 1'b0;
            r_uclk     <= 1'b0;
        end else begin
            r_new_data <= 1'b0;
            if (w_start) begin
                r_cnt      <= w_half_in;
                r_baud     <= bus.i_baud_rate;
                r_size     <= bus.i_data_size;
                r_par_en   <= bus.i_parity_en;
                r_par_mode <= bus.i_parity_mode;
                r_shift    <= '0;
                r_bit_idx  <= '0;
                r_par_ok   <= 1'b1;
                r_uclk     <= 1'b0;
            end else if (w_next == S_IDLE) begin
                r_uclk <= 1'b0;
            end else if (w_tick) begin
                r_cnt  <= w_period - CNT_W'(1);
                r_uclk <= 1'b1;
                if (r_state == S_DATA) begin
                    r_shift[r_bit_idx] <= r_rx_sync;
                    r_bit_idx          <= r_bit_idx + 3'd1;
                end
                if (r_state == S_PARITY) r_par_ok <= (r_rx_sync == w_par_exp);
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == w_fall) r_uclk <= 1'b0;
            end
            if (w_done) begin
                r_data     <= r_shift;
                r_valid    <= r_par_ok & r_rx_sync;
                r_new_data <= 1'b1;
            end
        end
    end

    // Ready is held low through the strobe cycle so it rises the cycle after.
    assign bus.o_ready      = (r_state == S_IDLE) & ~r_new_data;
    assign bus.o_data       = r_data;
    assign bus.o_valid      = r_valid;
    assign bus.o_new_data   = r_new_data;
    assign bus.o_uart_clock = r_uclk;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames compared
// against a frame-level model of the expected character, validity and timing.
module tb_uart_rx;
    localparam int unsigned CLK_HZ = 100_000_000;

    logic clk = 1'b0;
    logic rst;
    uart_rx_if bus ();

    uart_rx #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_fall   = 0;
    int nd_count = 0;
    int nd_cycle = 0;
    int uclk_rises = 0;
    logic uclk_prev = 1'b0;
    int baud_tab [8] = '{460800, 230400, 115200, 57600, 38400, 19200, 9600, 4800};

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.o_new_data === 1'b1) begin
            nd_count++;
            nd_cycle = cyc;
        end
        if (bus.o_uart_clock === 1'b1 && uclk_prev === 1'b0) uclk_rises++;
        uclk_prev = bus.o_uart_clock;
    end

    function automatic int period(input int sel);
        return (CLK_HZ + baud_tab[sel] / 2) / baud_tab[sel];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic drive_bit(input logic b, input int t);
        bus.i_rx = b;
        repeat (t) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit size8, input bit pen,
                              input bit pbit, input bit stopb, input int t);
        @(negedge clk);
        t_fall = cyc;
        drive_bit(1'b0, t);
        for (int i = 0; i < (size8 ? 8 : 7); i++) drive_bit(d[i], t);
        if (pen) drive_bit(pbit, t);
        drive_bit(stopb, t);
        bus.i_rx = 1'b1;
    endtask

    // Sends one frame and checks it against the frame-level model.
    task automatic do_frame(input string tag, input logic [7:0] d, input bit size8,
                            input bit pen, input logic [1:0] mode, input bit pbit,
                            input bit stopb, input int sel);
        int t, n, p, nd0, r0, exp_lat, ones;
        logic [7:0] exp_d;
        logic exp_par, exp_v;
        t = period(sel);
        n = size8 ? 8 : 7;
        p = pen ? 1 : 0;
        bus.i_baud_rate   = 3'(sel);
        bus.i_data_size   = size8;
        bus.i_parity_en   = pen;
        bus.i_parity_mode = mode;
        nd0 = nd_count;
        r0  = uclk_rises;
        send_frame(d, size8, pen, pbit, stopb, t);
        // A low stop bit would look like a new start edge; give the line a bit of idle.
        if (!stopb) repeat (t) @(negedge clk);
        exp_d = size8 ? d : (d & 8'h7f);
        ones  = $countones(exp_d);
        case (mode)
            2'b11:   exp_par = (ones % 2 == 0);
            2'b10:   exp_par = (ones % 2 == 1);
            2'b01:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
        exp_v   = stopb && (!pen || (pbit == exp_par));
        exp_lat = (1 + n + p) * t + t / 2;
        check({tag, ".strobes"}, nd_count - nd0, 1);
        check({tag, ".data"}, bus.o_data, exp_d);
        check({tag, ".valid"}, bus.o_valid, exp_v);
        check_range({tag, ".latency"}, nd_cycle - t_fall, exp_lat + 2, exp_lat + 4);
        check({tag, ".ready"}, bus.o_ready, 1'b1);
        check_range({tag, ".uclk_rises"}, uclk_rises - r0, 1 + n + p, 2 + n + p);
    endtask

    initial begin
        int t, nd0, c0;
        logic [7:0] d;
        bit size8, pen, pbit, stopb;
        logic [1:0] mode;
        int sel;

        rst = 1'b1;
        bus.i_en          = 1'b1;
        bus.i_rx          = 1'b1;
        bus.i_baud_rate   = 3'd0;
        bus.i_data_size   = 1'b1;
        bus.i_parity_en   = 1'b0;
        bus.i_parity_mode = 2'b00;
        repeat (5) @(negedge clk);
        check("reset.data", bus.o_data, 8'h00);
        check("reset.valid", bus.o_valid, 1'b0);
        check("reset.ready", bus.o_ready, 1'b1);
        check("reset.new_data", bus.o_new_data, 1'b0);
        check("reset.uclk", bus.o_uart_clock, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        do_frame("basic_mark",  8'h95, 1, 1, 2'b01, 1, 1, 0);
        do_frame("mark_perr",   8'h95, 1, 1, 2'b01, 0, 1, 0);
        do_frame("even7",       8'h55, 0, 1, 2'b10, 0, 1, 0);
        do_frame("odd8_ok",     8'h01, 1, 1, 2'b11, 0, 1, 0);
        do_frame("odd8_err",    8'h01, 1, 1, 2'b11, 1, 1, 0);
        do_frame("framing_err", 8'hA3, 1, 0, 2'b00, 0, 0, 0);
        do_frame("after_ferr",  8'h3C, 1, 0, 2'b00, 0, 1, 0);
        do_frame("b2b_space",   8'hC6, 1, 1, 2'b00, 0, 1, 0);

        // False start: low for a quarter bit only.
        t   = period(0);
        nd0 = nd_count;
        @(negedge clk);
        c0 = cyc;
        bus.i_rx = 1'b0;
        repeat (5) @(negedge clk);
        check("false_start.detect", bus.o_ready, 1'b0);
        repeat (t / 4 - 5) @(negedge clk);
        bus.i_rx = 1'b1;
        while (cyc < c0 + t / 2 + 4) @(negedge clk);
        check("false_start.ready", bus.o_ready, 1'b1);
        check("false_start.strobes", nd_count - nd0, 0);
        check("false_start.data", bus.o_data, 8'hC6);

        // Reset during bit 3.
        bus.i_baud_rate = 3'd0;
        bus.i_data_size = 1'b1;
        bus.i_parity_en = 1'b0;
        d = 8'hF0;
        @(negedge clk);
        drive_bit(1'b0, t);
        for (int i = 0; i < 3; i++) drive_bit(d[i], t);
        drive_bit(d[3], t / 2);
        rst = 1'b1;
        #1;
        check("rst_mid.data", bus.o_data, 8'h00);
        check("rst_mid.valid", bus.o_valid, 1'b0);
        check("rst_mid.ready", bus.o_ready, 1'b1);
        check("rst_mid.new_data", bus.o_new_data, 1'b0);
        check("rst_mid.uclk", bus.o_uart_clock, 1'b0);
        @(negedge clk);
        bus.i_rx = 1'b1;
        rst = 1'b0;
        repeat (12 * t) @(negedge clk);
        check("rst_mid.strobes", nd_count - nd0, 0);
        do_frame("after_rst", 8'h5A, 1, 0, 2'b00, 0, 1, 2);

        // Enable dropped during bit 3; the rest of the frame arrives while disabled.
        nd0 = nd_count;
        bus.i_baud_rate = 3'd0;
        d = 8'hE7;
        @(negedge clk);
        drive_bit(1'b0, t);
        for (int i = 0; i < 3; i++) drive_bit(d[i], t);
        drive_bit(d[3], t / 2);
        bus.i_en = 1'b0;
        @(negedge clk);
        check("en_abort.ready", bus.o_ready, 1'b1);
        check("en_abort.uclk", bus.o_uart_clock, 1'b0);
        repeat (t / 2) @(negedge clk);
        for (int i = 4; i < 8; i++) drive_bit(d[i], t);
        drive_bit(1'b1, 2 * t);
        check("en_abort.strobes", nd_count - nd0, 0);
        check("en_abort.data", bus.o_data, 8'h5A);
        check("en_abort.valid", bus.o_valid, 1'b1);
        bus.i_en = 1'b1;
        repeat (4) @(negedge clk);
        do_frame("after_en", 8'h81, 1, 1, 2'b10, 0, 1, 0);

        for (int k = 0; k < 5; k++) begin
            sel   = int'($urandom_range(0, 1));
            d     = 8'($urandom);
            size8 = 1'($urandom_range(0, 1));
            pen   = 1'($urandom_range(0, 1));
            mode  = 2'($urandom_range(0, 3));
            pbit  = 1'($urandom_range(0, 1));
            stopb = ($urandom_range(0, 5) != 0);
            do_frame($sformatf("rand%0d", k), d, size8, pen, mode, pbit, stopb, sel);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
